// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the up/down digit chain.
// Optional lap/freeze display: define BCD_LAP_HOLD_EN.
package bcd_pkg;
    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 16;

    typedef logic [BCD_W-1:0] bcd_t;

    function automatic bcd_t digit_max(
        input logic [BCD_W*MAX_DIGITS-1:0] dmax,
        input int                          i
    );
        return dmax[BCD_W*i +: BCD_W];
    endfunction
endpackage

// File: rtl/bcd_digit_ud.sv
// One BCD digit with up/down step, clear and clamped preset load.
// The carry/borrow enables come from the parent chain.
module bcd_digit_ud
    import bcd_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t digit,
    output logic at_max,
    output logic at_zero
);
    bcd_t r_digit;
    bcd_t w_load;

    // Non-BCD nibbles are above any legal MAX, so one compare clamps both.
    assign w_load  = (load_val > MAX) ? MAX : load_val;
    assign at_max  = (r_digit == MAX);
    assign at_zero = (r_digit == '0);
    assign digit   = r_digit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= w_load;
        end else if (inc) begin
            r_digit <= at_max ? '0 : r_digit + 4'd1;
        end else if (dec) begin
            r_digit <= at_zero ? MAX : r_digit - 4'd1;
        end
    end
endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with wrap/saturate terminal handling.
// Optional lap/freeze display: define BCD_LAP_HOLD_EN.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int                      NUM_DIGITS = 5,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 20'h59599,
    parameter bit                      WRAP       = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic                      tick,
    input  logic                      down,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic                      at_zero,
    output logic                      done,
    output logic                      overflow
`ifdef BCD_LAP_HOLD_EN
    ,
    input  logic                      lap,
    output logic [4*NUM_DIGITS-1:0]   display
`endif
);
    logic [4*NUM_DIGITS-1:0] w_digits;
    logic [NUM_DIGITS-1:0]   w_at_max;
    logic [NUM_DIGITS-1:0]   w_at_zero;
    logic [NUM_DIGITS-1:0]   w_inc;
    logic [NUM_DIGITS-1:0]   w_dec;
    logic                    w_up;
    logic                    w_dn;
    logic                    w_all_max;
    logic                    w_all_zero;
    logic                    w_is_one;
    logic                    w_term;
    logic                    w_hold;
    logic                    r_done;
    logic                    r_overflow;

    assign w_up       = tick && !down && !clr && !load;
    assign w_dn       = tick &&  down && !clr && !load;
    assign w_all_max  = &w_at_max;
    assign w_all_zero = &w_at_zero;
    assign w_is_one   = (w_digits == (4*NUM_DIGITS)'(1));
    assign w_term     = (w_up && w_all_max) || (w_dn && w_all_zero);
    assign w_hold     = !WRAP && w_term;

    // Digit i steps only when every lower digit is at its rollover point.
    always_comb begin : chain
        logic v_cy;
        logic v_bw;
        v_cy  = 1'b1;
        v_bw  = 1'b1;
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_inc[i] = w_up && !w_hold && v_cy;
            w_dec[i] = w_dn && !w_hold && v_bw;
            v_cy     = v_cy && w_at_max[i];
            v_bw     = v_bw && w_at_zero[i];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_digit_ud #(
            .MAX(digit_max(64'(DIGIT_MAX), g))
        ) u_dig (
            .clk     (clk),
            .reset   (reset),
            .inc     (w_inc[g]),
            .dec     (w_dec[g]),
            .clr     (clr),
            .load    (load),
            .load_val(load_value[4*g +: 4]),
            .digit   (w_digits[4*g +: 4]),
            .at_max  (w_at_max[g]),
            .at_zero (w_at_zero[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done     <= w_dn && w_is_one;
            r_overflow <= w_term;
        end
    end

    assign digits   = w_digits;
    assign at_zero  = w_all_zero;
    assign done     = r_done;
    assign overflow = r_overflow;

`ifdef BCD_LAP_HOLD_EN
    logic                    r_frozen;
    logic [4*NUM_DIGITS-1:0] r_display;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frozen  <= 1'b0;
            r_display <= '0;
        end else begin
            if (clr) begin
                r_frozen <= 1'b0;
            end else if (lap) begin
                r_frozen <= !r_frozen;
            end
            if (!r_frozen || clr || lap) begin
                r_display <= w_digits;
            end
        end
    end

    assign display = r_display;
`endif
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: WRAP=1 and WRAP=0 counters driven in lockstep.
// Lap/display checks run when BCD_LAP_HOLD_EN is defined.
module tb_bcd_updown_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [19:0] load_value = '0;
    logic        tick = 1'b0;
    logic        down = 1'b0;
    logic [19:0] dig_w, dig_s;
    logic        az_w, az_s;
    logic        done_w, done_s;
    logic        ovf_w, ovf_s;
`ifdef BCD_LAP_HOLD_EN
    logic        lap = 1'b0;
    logic [19:0] disp_w, disp_s;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.NUM_DIGITS(5), .DIGIT_MAX(20'h59599), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load),
        .load_value(load_value), .tick(tick), .down(down),
        .digits(dig_w), .at_zero(az_w), .done(done_w), .overflow(ovf_w)
`ifdef BCD_LAP_HOLD_EN
        , .lap(lap), .display(disp_w)
`endif
    );

    bcd_updown_counter #(.NUM_DIGITS(5), .DIGIT_MAX(20'h59599), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .load(load),
        .load_value(load_value), .tick(tick), .down(down),
        .digits(dig_s), .at_zero(az_s), .done(done_s), .overflow(ovf_s)
`ifdef BCD_LAP_HOLD_EN
        , .lap(lap), .display(disp_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string tag, input logic [19:0] ew,
                            input logic [19:0] es, input logic eow,
                            input logic eos, input logic edn);
        check({tag, " dig_w"}, 32'(dig_w), 32'(ew));
        check({tag, " dig_s"}, 32'(dig_s), 32'(es));
        check({tag, " ovf_w"}, 32'(ovf_w), 32'(eow));
        check({tag, " ovf_s"}, 32'(ovf_s), 32'(eos));
        check({tag, " done_w"}, 32'(done_w), 32'(edn));
        check({tag, " done_s"}, 32'(done_s), 32'(edn));
    endtask

    task automatic do_load(input logic [19:0] v);
        load = 1'b1; load_value = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        #12;
        chk_both("rst", 20'h0, 20'h0, 1'b0, 1'b0, 1'b0);
        check("rst az", 32'(az_w), 32'd1);
        reset = 1'b1;
        step();

        do_load(20'h00120);
        tick = 1'b1; down = 1'b0;
        repeat (3) step();
        tick = 1'b0;
        chk_both("cnt123", 20'h00123, 20'h00123, 1'b0, 1'b0, 1'b0);
        check("cnt123 az", 32'(az_w), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk_both("async", 20'h0, 20'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();

        do_load(20'h09599);
        tick = 1'b1; down = 1'b0;
        step();
        tick = 1'b0;
        chk_both("carry", 20'h10000, 20'h10000, 1'b0, 1'b0, 1'b0);

        do_load(20'h59599);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk_both("upterm", 20'h00000, 20'h59599, 1'b1, 1'b1, 1'b0);
        step();
        chk_both("upterm+1", 20'h00000, 20'h59599, 1'b0, 1'b0, 1'b0);

        do_load(20'h10000);
        tick = 1'b1; down = 1'b1;
        step();
        tick = 1'b0;
        chk_both("borrow", 20'h09599, 20'h09599, 1'b0, 1'b0, 1'b0);

        do_load(20'h00002);
        tick = 1'b1; down = 1'b1;
        step();
        chk_both("dn1", 20'h00001, 20'h00001, 1'b0, 1'b0, 1'b0);
        step();
        chk_both("dn0", 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b1);
        check("dn0 az", 32'(az_s), 32'd1);
        step();
        chk_both("dnterm", 20'h59599, 20'h00000, 1'b1, 1'b1, 1'b0);
        tick = 1'b0;
        step();
        chk_both("dnterm+1", 20'h59599, 20'h00000, 1'b0, 1'b0, 1'b0);

        down = 1'b0; step(); down = 1'b1; step(); down = 1'b0;
        chk_both("hold", 20'h59599, 20'h00000, 1'b0, 1'b0, 1'b0);

        clr = 1'b1; load = 1'b1; tick = 1'b1; load_value = 20'h12345;
        step();
        clr = 1'b0; load = 1'b0; tick = 1'b0;
        chk_both("prio", 20'h0, 20'h0, 1'b0, 1'b0, 1'b0);

        do_load(20'h7FFFF);
        chk_both("clamp", 20'h59599, 20'h59599, 1'b0, 1'b0, 1'b0);
        do_load(20'h34567);
        chk_both("ld", 20'h34567, 20'h34567, 1'b0, 1'b0, 1'b0);

        load = 1'b1; tick = 1'b1; down = 1'b0; load_value = 20'h00005;
        step();
        load = 1'b0; tick = 1'b0;
        chk_both("ldtick", 20'h00005, 20'h00005, 1'b0, 1'b0, 1'b0);

`ifdef BCD_LAP_HOLD_EN
        do_load(20'h00100);
        tick = 1'b1; down = 1'b0; lap = 1'b1;
        step();
        lap = 1'b0;
        check("lap cap", 32'(disp_w), 32'h00100);
        check("lap dig", 32'(dig_w), 32'h00101);
        step(); step();
        check("lap frz", 32'(disp_w), 32'h00100);
        check("lap run", 32'(dig_w), 32'h00103);
        lap = 1'b1;
        step();
        lap = 1'b0;
        check("lap rel", 32'(disp_s), 32'h00103);
        step();
        check("lap trk", 32'(disp_w), 32'h00104);
        check("lap trk d", 32'(dig_w), 32'h00105);
        tick = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised N-digit BCD counter with per-digit rollover limits, up/down counting, synchronous preset load and wrap/saturate terminal handling.
- Next generation of the stopwatch digit chain; also serves countdown timer and lap-display use.
- Sits between the tick prescaler and the 7-segment display multiplexer.

Parameters:
- NUM_DIGITS, 5, number of BCD digits; digit 0 is least significant.
- DIGIT_MAX, 20'h59599, packed 4 bits per digit; digit i rolls over above DIGIT_MAX[4i+3:4i]. Each field must be 1..9.
- WRAP, 1, 1 = wrap at the terminal count; 0 = saturate at the terminal count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while reset==0.
- clr  in  1  synchronous clear to all-zero.
- load  in  1  synchronous load of load_value.
- load_value  in  4*NUM_DIGITS  preset value, packed BCD.
- tick  in  1  count enable, one step per cycle when high.
- down  in  1  0 = count up, 1 = count down; sampled with tick.
- digits  out  4*NUM_DIGITS  current count, packed BCD.
- at_zero  out  1  combinational: digits == 0.
- done  out  1  one-cycle pulse: a down-tick reached all-zero.
- overflow  out  1  one-cycle pulse: terminal count hit (up past all-max, or down past all-zero).

Behaviour:
- Reset (async assert, sync release): digits=0, done=0, overflow=0.
- Priority per cycle: clr > load > tick. When clr or load is high, the tick is dropped.
- Load: digit i := min(load_value field, DIGIT_MAX field). Non-BCD or over-limit nibbles clamp to that digit's max. done and overflow stay 0.
- Up tick: digit i increments iff every lower digit equals its max. A digit at its max goes to 0 and propagates the carry.
- Down tick: digit i decrements iff every lower digit equals 0. A digit at 0 goes to its max and propagates the borrow.
- The carry/borrow chain is combinational within one cycle. All digits update on the same edge, so the result is visible the cycle after tick.
- Up from all-max:
  - WRAP=1: digits become all-zero and overflow pulses.
  - WRAP=0: digits hold all-max and overflow pulses.
- Down from all-zero:
  - WRAP=1: digits become all-max and overflow pulses.
  - WRAP=0: digits hold zero, overflow pulses, done stays 0.
- done: registered. It is 1 in the cycle after a down-tick moves digits from a nonzero value to zero.
- done and overflow are never both 1 in the same cycle. Both pulses are registered and last exactly one cycle.
- tick=0: digits hold. down may change freely without effect.
- If reset asserts mid-count, outputs clear immediately without waiting for clk.

Optional Feature:
- Macro: BCD_LAP_HOLD_EN.
- With the macro, add these ports:
  - lap (in, 1): toggles freeze mode.
  - display (out, 4*NUM_DIGITS): registered view of the count.
- Freeze mode behaviour:
  - While not frozen, display tracks digits with one cycle of delay.
  - A lap pulse while not frozen captures the count into display and freezes it.
  - A lap pulse while frozen resumes tracking.
  - Counting continues underneath the whole time.
  - clr and reset both unfreeze, and reset clears display.
- Without the macro, the lap and display ports do not exist and there is no extra logic.

Decomposition:
- Package bcd_pkg:
  - BCD_W=4.
  - typedef bcd_t (4-bit).
  - Function digit_max(DIGIT_MAX, i).
- Sub-module bcd_digit_ud: one digit with parameter MAX.
  - Inputs: inc, dec, clr, load, load_val.
  - Outputs: digit, at_max, at_zero.
  - The top level builds the carry/borrow enables with a generate loop.
  - The top level also holds the terminal flag registers and the lap logic.

Test Plan:
- Reset/async: count to 00123, pull reset low between edges -> digits=0 immediately; done=overflow=0.
- Up rollover chain: load 09599, tick up once -> 10000 next cycle; no overflow.
- Up terminal, WRAP=1: load 59599, tick up -> 00000 and overflow=1 for one cycle. With WRAP=0 -> holds 59599 and overflow pulses.
- Countdown: load 00002, tick down twice -> 00001, then 00000 with done=1 for one cycle. A further tick with WRAP=0 holds 00000 and pulses overflow; with WRAP=1 it gives 59599.
- Priority and clamp: load, tick and clr high together -> 00000. load_value 0x7F_FFF -> 59599 (clamped).
- BCD_LAP_HOLD_EN: count to 00100, pulse lap -> display freezes at 00100 while digits keep advancing. A second lap pulse -> display tracks again (one-cycle lag).
